// File: rtl/pipe1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe1_pkg
//  Description : Shared defaults, FSM state encoding and the saturating
//                increment helper for the pipe1 checker and its model.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe1_pkg;

    localparam int unsigned DEF_N   = 8;
    localparam int unsigned DEF_LAT = 3;
    localparam int unsigned DEF_CW  = 16;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t HALT = 2'd2;

    // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe1_model.sv
`default_nettype none
// ============================================================================
//  Module      : pipe1_model
//  Description : Reference model of the pipe1 datapath, F = ((A+B)+(C-D))*D
//                modulo 2^N, with a valid tag riding alongside each operand
//                set. Three arithmetic stages followed by LAT-3 delay stages.
//  Ports       : clk, rst_n (async, active-low), flush (drops all tags),
//                in_valid/a/b/c/d (operand capture), exp_valid/exp (result
//                leaving the last stage).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe1_model
    import pipe1_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int LAT = DEF_LAT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    input  logic [N-1:0] d,
    output logic         exp_valid,
    output logic [N-1:0] exp
);

    logic [N-1:0] r_s1, r_x1, r_d1;
    logic [N-1:0] r_z2, r_d2;
    logic [N-1:0] r_e3;
    logic         r_v1, r_v2, r_v3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_x1 <= '0;
            r_d1 <= '0;
            r_z2 <= '0;
            r_d2 <= '0;
            r_e3 <= '0;
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            // Operands enter only with a valid strobe; later stages shift freely
            // because their contents are qualified by the tag.
            if (in_valid) begin
                r_s1 <= a + b;
                r_x1 <= c - d;
                r_d1 <= d;
            end
            r_z2 <= r_s1 + r_x1;
            r_d2 <= r_d1;
            r_e3 <= r_z2 * r_d2;
            if (flush) begin
                r_v1 <= 1'b0;
                r_v2 <= 1'b0;
                r_v3 <= 1'b0;
            end else begin
                r_v1 <= in_valid;
                r_v2 <= r_v1;
                r_v3 <= r_v2;
            end
        end
    end

    generate
        if (LAT > 3) begin : g_delay
            localparam int DEPTH = LAT - 3;
            logic [N-1:0]     r_dly_e [DEPTH];
            logic [DEPTH-1:0] r_dly_v;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) r_dly_e[i] <= '0;
                    r_dly_v <= '0;
                end else begin
                    r_dly_e[0] <= r_e3;
                    r_dly_v[0] <= r_v3 & ~flush;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_dly_e[i] <= r_dly_e[i-1];
                        r_dly_v[i] <= r_dly_v[i-1] & ~flush;
                    end
                end
            end

            assign exp       = r_dly_e[DEPTH-1];
            assign exp_valid = r_dly_v[DEPTH-1];
        end else begin : g_direct
            assign exp       = r_e3;
            assign exp_valid = r_v3;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pipe1_checker.sv
`default_nettype none
// ============================================================================
//  Module      : pipe1_checker
//  Description : Consumes the pipe1 result stream F, compares it against a
//                matched-latency model, counts passes/errors (saturating) and
//                captures the first mismatch. Optionally halts on first error.
//  Ports       : clk, rst_n (async, active-low), in_valid/a/b/c/d (operands
//                applied to pipe1), f (pipe1 result), clr (sync clear);
//                pass_cnt, err_cnt, err_flag, first_exp, first_got, busy,
//                halted.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe1_checker
    import pipe1_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int LAT         = DEF_LAT,
    parameter int CW          = DEF_CW,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic [N-1:0]  c,
    input  logic [N-1:0]  d,
    input  logic [N-1:0]  f,
    input  logic          clr,
    output logic [CW-1:0] pass_cnt,
    output logic [CW-1:0] err_cnt,
    output logic          err_flag,
    output logic [N-1:0]  first_exp,
    output logic [N-1:0]  first_got,
    output logic          busy,
    output logic          halted
);

    localparam int IFW = $clog2(LAT + 1);

    state_t         r_state;
    logic [CW-1:0]  r_pass_cnt, r_err_cnt;
    logic           r_err_flag;
    logic [N-1:0]   r_first_exp, r_first_got;
    // Number of valid tags inside the model; nonzero exactly when any tag is set.
    logic [IFW-1:0] r_inflight;

    logic           w_flush, w_accept, w_cmp, w_mismatch, w_exp_valid;
    logic [N-1:0]   w_exp;

    assign w_flush    = clr | (r_state == HALT);
    assign w_accept   = in_valid & ~w_flush;
    assign w_cmp      = w_exp_valid & ~w_flush;
    assign w_mismatch = w_cmp & (w_exp != f);

    pipe1_model #(
        .N   (N),
        .LAT (LAT)
    ) u_model (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (w_flush),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .exp_valid (w_exp_valid),
        .exp       (w_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pass_cnt  <= '0;
            r_err_cnt   <= '0;
            r_err_flag  <= 1'b0;
            r_first_exp <= '0;
            r_first_got <= '0;
            r_inflight  <= '0;
        end else if (clr) begin
            r_state     <= IDLE;
            r_pass_cnt  <= '0;
            r_err_cnt   <= '0;
            r_err_flag  <= 1'b0;
            r_first_exp <= '0;
            r_first_got <= '0;
            r_inflight  <= '0;
        end else begin
            if (r_state == HALT) begin
                r_inflight <= '0;
            end else begin
                r_inflight <= r_inflight + IFW'(w_accept) - IFW'(w_cmp);
            end

            if (w_cmp) begin
                if (w_mismatch) begin
                    r_err_cnt  <= CW'(sat_inc(32'(r_err_cnt), CW));
                    r_err_flag <= 1'b1;
                    if (!r_err_flag) begin
                        r_first_exp <= w_exp;
                        r_first_got <= f;
                    end
                end else begin
                    r_pass_cnt <= CW'(sat_inc(32'(r_pass_cnt), CW));
                end
            end

            case (r_state)
                IDLE: begin
                    if (in_valid) r_state <= RUN;
                end
                RUN: begin
                    if (w_mismatch && STOP_ON_ERR) begin
                        r_state <= HALT;
                    end else if ((r_inflight == '0) && !in_valid) begin
                        r_state <= IDLE;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pass_cnt  = r_pass_cnt;
    assign err_cnt   = r_err_cnt;
    assign err_flag  = r_err_flag;
    assign first_exp = r_first_exp;
    assign first_got = r_first_got;
    assign busy      = (r_inflight != '0);
    assign halted    = (r_state == HALT);

endmodule
`default_nettype wire

// File: tb/tb_pipe1_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe1_checker
//  Description : Directed bench for pipe1_checker. Two instances share all
//                stimulus: one continues after errors, one halts on the first.
//                Counters are 4 bits wide so saturation is reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe1_checker;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a, b, c, d, f;
    logic       clr;

    logic [3:0] c_pass, c_err, h_pass, h_err;
    logic       c_flag, c_busy, c_halt, h_flag, h_busy, h_halt;
    logic [7:0] c_fexp, c_fgot, h_fexp, h_fgot;

    int vectors     = 0;
    int miscompares = 0;

    pipe1_checker #(.N(8), .LAT(3), .CW(4), .STOP_ON_ERR(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .d(d), .f(f), .clr(clr),
        .pass_cnt(c_pass), .err_cnt(c_err), .err_flag(c_flag),
        .first_exp(c_fexp), .first_got(c_fgot), .busy(c_busy), .halted(c_halt)
    );

    pipe1_checker #(.N(8), .LAT(3), .CW(4), .STOP_ON_ERR(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a), .b(b), .c(c), .d(d), .f(f), .clr(clr),
        .pass_cnt(h_pass), .err_cnt(h_err), .err_flag(h_flag),
        .first_exp(h_fexp), .first_got(h_fgot), .busy(h_busy), .halted(h_halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        vectors++;
        assert (got === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp_v);
        end
    endtask

    // Present one set of inputs, let one rising edge sample them, then settle.
    task automatic step(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] ic, input logic [7:0] id,
                        input logic [7:0] ifv, input logic iclr = 1'b0);
        in_valid = v;
        a        = ia;
        b        = ib;
        c        = ic;
        d        = id;
        f        = ifv;
        clr      = iclr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] fval;
        rst_n = 1'b1; in_valid = 1'b0; clr = 1'b0;
        a = '0; b = '0; c = '0; d = '0; f = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_counts", {c_pass, c_err, h_pass, h_err}, 32'h0);
        chk("reset_flags", {c_flag, c_busy, c_halt, h_flag, h_busy, h_halt}, 32'h0);
        chk("reset_first", {c_fexp, c_fgot}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back stream, correct results 03, 0E, 21
        step(1, 8'd1, 8'd1, 8'd2, 8'd1, 8'h00);
        step(1, 8'd2, 8'd3, 8'd4, 8'd2, 8'h00);
        step(1, 8'd3, 8'd5, 8'd6, 8'd3, 8'h00);
        step(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h03);
        step(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h0E);
        chk("stream_busy_mid", 32'(c_busy), 32'd1);
        chk("stream_pass_mid", 32'(c_pass), 32'd2);
        step(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h21);
        chk("stream_pass", 32'(c_pass), 32'd3);
        chk("stream_err", 32'(c_err), 32'd0);
        chk("stream_busy_end", 32'(c_busy), 32'd0);
        chk("stream_pass_h", 32'(h_pass), 32'd3);

        // Wrap-around 0x99 and underflow 0xFF
        step(1, 8'd200, 8'd100, 8'd10, 8'd3, 8'h00);
        step(1, 8'd0, 8'd0, 8'd0, 8'd1, 8'h00);
        step(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h00);
        step(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h99);
        step(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'hFF);
        chk("wrap_pass", 32'(c_pass), 32'd5);
        chk("wrap_err", 32'(c_err), 32'd0);

        // Corrupted f on (2,3,4,2) compare; halting instance stops here
        step(1, 8'd2, 8'd3, 8'd4, 8'd2, 8'h00);
        step(1, 8'd1, 8'd1, 8'd2, 8'd1, 8'h00);
        step(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h00);
        step(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h00);
        chk("err1_cnt", 32'(c_err), 32'd1);
        chk("err1_flag", 32'(c_flag), 32'd1);
        chk("err1_first", {c_fexp, c_fgot}, 32'h0E00);
        chk("err1_h_halt", {h_halt, h_flag, h_err}, {26'd0, 1'b1, 1'b1, 4'd1});
        chk("err1_h_first", {h_fexp, h_fgot}, 32'h0E00);
        step(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h03);
        chk("err1_after_pass", 32'(c_pass), 32'd6);
        chk("halt_pass_frozen", 32'(h_pass), 32'd5);

        // Second error: first_* unchanged; halted instance ignores in_valid
        step(1, 8'd3, 8'd5, 8'd6, 8'd3, 8'h00);
        step(1, 8'd1, 8'd1, 8'd2, 8'd1, 8'h00);
        step(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h00);
        step(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h55);
        step(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h03);
        chk("err2_cnt", 32'(c_err), 32'd2);
        chk("err2_first", {c_fexp, c_fgot}, 32'h0E00);
        chk("err2_pass", 32'(c_pass), 32'd7);
        chk("halt_frozen", {h_pass, h_err, h_fexp, h_fgot}, {8'h00, 4'd5, 4'd1, 8'h0E, 8'h00});
        chk("halt_state", {h_halt, h_busy}, 32'b10);

        // clr returns both instances to a clean IDLE
        step(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h00, 1'b1);
        chk("clr_c", {c_pass, c_err, c_flag, c_fexp, c_fgot, c_busy, c_halt}, 32'h0);
        chk("clr_h", {h_pass, h_err, h_flag, h_fexp, h_fgot, h_busy, h_halt}, 32'h0);
        step(1, 8'd1, 8'd1, 8'd2, 8'd1, 8'h00);
        step(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h00);
        step(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h00);
        step(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h03);
        chk("fresh_pass", {h_pass, c_pass}, 32'h11);
        chk("fresh_err", {h_err, c_err, h_halt}, 32'h0);

        // Bubbles: garbage on in_valid=0 slots never loads or compares
        step(1, 8'd2, 8'd3, 8'd4, 8'd2, 8'h00);
        step(0, 8'd9, 8'd9, 8'd9, 8'd9, 8'h00);
        step(1, 8'd1, 8'd1, 8'd2, 8'd1, 8'h00);
        step(0, 8'd9, 8'd9, 8'd9, 8'd9, 8'h0E);
        step(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h77);
        chk("bubble_mid", 32'(c_pass), 32'd2);
        step(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h03);
        chk("bubble_pass", 32'(c_pass), 32'd3);
        chk("bubble_err", 32'(c_err), 32'd0);

        // Reset with two items in flight
        step(1, 8'd1, 8'd1, 8'd2, 8'd1, 8'h00);
        step(1, 8'd2, 8'd3, 8'd4, 8'd2, 8'h00);
        rst_n = 1'b0;
        #1;
        chk("midrst_now", {c_pass, c_err, c_busy, h_pass, h_busy}, 32'h0);
        step(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h5A);
        chk("midrst_after", {c_pass, c_err, c_flag, c_busy}, 32'h0);

        // 18 back-to-back matching items; 4-bit pass counter holds at 0xF
        for (int i = 0; i < 21; i++) begin
            fval = (i >= 3) ? 8'(i - 1) : 8'h00;
            step(i < 18, 8'(i), 8'd1, 8'd2, 8'd1, fval);
            if (i == 17) begin
                chk("sat_mid_pass", 32'(c_pass), 32'd15);
                chk("sat_mid_busy", 32'(c_busy), 32'd1);
            end
        end
        chk("sat_pass", {h_pass, c_pass}, 32'hFF);
        chk("sat_err", {h_err, c_err, c_busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
